// File: rtl/stream_classify_demux.sv
// AXI-Stream 1:N packet demultiplexer: classifies each packet on its first beat
// against masked match rules and steers the whole packet into one output slot.
module stream_classify_demux #(
  parameter int DATA_W = 512,
  parameter int USER_W = 137,
  parameter int MATCH_W = 64,
  parameter int NUM_MATCH = 2,
  parameter logic [NUM_MATCH*MATCH_W-1:0] MATCH_VALS = {64'h0ADDBEEFDEADBEEF, 64'h0},
  parameter logic [NUM_MATCH*MATCH_W-1:0] MATCH_MASK = {(NUM_MATCH*MATCH_W){1'b1}},
  parameter bit DROP_UNMATCHED = 1'b0,
  localparam int KEEP_W = DATA_W/8,
  localparam int NUM_PORTS = NUM_MATCH+1,
  localparam int PW = $clog2(NUM_PORTS)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [DATA_W-1:0]           s_axis_tdata,
  input  logic [KEEP_W-1:0]           s_axis_tkeep,
  input  logic [USER_W-1:0]           s_axis_tuser,
  input  logic                        s_axis_tlast,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [NUM_PORTS*DATA_W-1:0] m_axis_tdata,
  output logic [NUM_PORTS*KEEP_W-1:0] m_axis_tkeep,
  output logic [NUM_PORTS*USER_W-1:0] m_axis_tuser,
  output logic [NUM_PORTS-1:0]        m_axis_tlast,
  output logic [NUM_PORTS-1:0]        m_axis_tvalid,
  input  logic [NUM_PORTS-1:0]        m_axis_tready,
  output logic [NUM_PORTS*32-1:0]     pkt_count,
  output logic [31:0]                 drop_count
);

  // state | meaning
  // SOP   | next accepted beat is a first beat; classify live on tdata
  // PKT   | forwarding remaining beats to lock_q
  // DROP  | discarding remaining beats of an unmatched packet
  typedef enum logic [1:0] {SOP, PKT, DROP} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       lock_q, lock_d;
  logic [PW-1:0]       sel, tgt;
  logic                sel_drop, dropping, accept;
  logic [NUM_PORTS-1:0] slot_free, load;

  logic [DATA_W-1:0]   tdata_q [NUM_PORTS];
  logic [KEEP_W-1:0]   tkeep_q [NUM_PORTS];
  logic [USER_W-1:0]   tuser_q [NUM_PORTS];
  logic [NUM_PORTS-1:0] tlast_q, tvalid_q;
  logic [31:0]         pkt_cnt_q [NUM_PORTS];
  logic [31:0]         drop_cnt_q;

  // Descending scan so the lowest matching rule wins.
  always_comb begin
    sel = PW'(NUM_MATCH);
    for (int i = NUM_MATCH-1; i >= 0; i--) begin
      if (((s_axis_tdata[MATCH_W-1:0] ^ MATCH_VALS[i*MATCH_W +: MATCH_W])
           & MATCH_MASK[i*MATCH_W +: MATCH_W]) == '0)
        sel = PW'(i);
    end
  end

  assign sel_drop  = DROP_UNMATCHED && (sel == PW'(NUM_MATCH));
  assign slot_free = ~tvalid_q | m_axis_tready;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= SOP;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    if (accept) begin
      case (state_q)
        SOP: if (!s_axis_tlast) begin
          state_d = sel_drop ? DROP : PKT;
          lock_d  = sel;
        end
        default: if (s_axis_tlast) state_d = SOP;
      endcase
    end
  end

  always_comb begin
    tgt           = (state_q == SOP) ? sel : lock_q;
    dropping      = (state_q == DROP) || ((state_q == SOP) && sel_drop);
    s_axis_tready = dropping ? 1'b1 : slot_free[tgt];
    accept        = s_axis_tvalid && s_axis_tready;
    load          = '0;
    if (accept && !dropping) load[tgt] = 1'b1;
  end

  // Data registers keep their last value after a drain; only tvalid clears.
  always_ff @(posedge CLK) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!RST) begin
        tvalid_q[p] <= 1'b0;
        tlast_q[p]  <= 1'b0;
        tdata_q[p]  <= '0;
        tkeep_q[p]  <= '0;
        tuser_q[p]  <= '0;
      end else if (load[p]) begin
        tvalid_q[p] <= 1'b1;
        tlast_q[p]  <= s_axis_tlast;
        tdata_q[p]  <= s_axis_tdata;
        tkeep_q[p]  <= s_axis_tkeep;
        tuser_q[p]  <= s_axis_tuser;
      end else if (m_axis_tready[p]) begin
        tvalid_q[p] <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      drop_cnt_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) pkt_cnt_q[p] <= '0;
    end else begin
      if (accept && dropping && s_axis_tlast) drop_cnt_q <= drop_cnt_q + 32'd1;
      for (int p = 0; p < NUM_PORTS; p++)
        if (tvalid_q[p] && m_axis_tready[p] && tlast_q[p]) pkt_cnt_q[p] <= pkt_cnt_q[p] + 32'd1;
    end
  end

  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_out
    assign m_axis_tdata[gp*DATA_W +: DATA_W] = tdata_q[gp];
    assign m_axis_tkeep[gp*KEEP_W +: KEEP_W] = tkeep_q[gp];
    assign m_axis_tuser[gp*USER_W +: USER_W] = tuser_q[gp];
    assign pkt_count[gp*32 +: 32]            = pkt_cnt_q[gp];
  end

  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_stream_classify_demux.sv
// Bench for stream_classify_demux: three instances (default routing, drop mode,
// wildcard rule) share stimulus; a queue-based packet model scores the selected one.
module tb_stream_classify_demux;
  localparam int DW = 512, UW = 137, KW = 64;
  localparam logic [63:0] R0 = 64'h0ADDBEEFDEADBEEF, R1 = 64'h0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic CLK, RST;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic [UW-1:0] s_tuser;
  logic s_tlast, s_tvalid;
  logic [2:0] s_tready;
  logic [2:0] m_tready;
  logic [3*DW-1:0] m_tdata [3];
  logic [3*KW-1:0] m_tkeep [3];
  logic [3*UW-1:0] m_tuser [3];
  logic [2:0] m_tlast [3];
  logic [2:0] m_tvalid [3];
  logic [95:0] pkt_count [3];
  logic [31:0] drop_count [3];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  stream_classify_demux #(.MATCH_VALS({R1, R0})) dut0 (
    .CLK(CLK), .RST(RST), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready[0]), .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]),
    .m_axis_tuser(m_tuser[0]), .m_axis_tlast(m_tlast[0]), .m_axis_tvalid(m_tvalid[0]),
    .m_axis_tready(m_tready), .pkt_count(pkt_count[0]), .drop_count(drop_count[0]));

  stream_classify_demux #(.MATCH_VALS({R1, R0}), .DROP_UNMATCHED(1'b1)) dut1 (
    .CLK(CLK), .RST(RST), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready[1]), .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]),
    .m_axis_tuser(m_tuser[1]), .m_axis_tlast(m_tlast[1]), .m_axis_tvalid(m_tvalid[1]),
    .m_axis_tready(m_tready), .pkt_count(pkt_count[1]), .drop_count(drop_count[1]));

  stream_classify_demux #(.MATCH_VALS({R1, R0}), .MATCH_MASK({64'h0, {64{1'b1}}})) dut2 (
    .CLK(CLK), .RST(RST), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready[2]), .m_axis_tdata(m_tdata[2]), .m_axis_tkeep(m_tkeep[2]),
    .m_axis_tuser(m_tuser[2]), .m_axis_tlast(m_tlast[2]), .m_axis_tvalid(m_tvalid[2]),
    .m_axis_tready(m_tready), .pkt_count(pkt_count[2]), .drop_count(drop_count[2]));

  int n_checks = 0, n_fail = 0;
  int cur = 0;
  beat_t in_q[$];
  beat_t expq[3][$];
  beat_t held[3];
  bit stall_prev[3];
  int exp_pkt[3];
  int exp_drop;
  bit in_pkt, drop_mode;
  int lock;

  // Port the specification's routing rules pick for a first beat on instance d.
  function automatic int classify(int d, logic [63:0] lo);
    if (lo == R0) return 0;
    if (d == 2 || lo == R1) return 1;
    return 2;
  endfunction

  function automatic beat_t rand_beat(int kind, bit last);
    beat_t b;
    logic [159:0] u;
    for (int i = 0; i < 16; i++) b.data[i*32 +: 32] = $urandom;
    for (int i = 0; i < 5; i++) u[i*32 +: 32] = $urandom;
    b.user = u[UW-1:0];
    b.keep = {$urandom, $urandom};
    b.last = last;
    case (kind)
      0: b.data[63:0] = R0;
      1: b.data[63:0] = R1;
      default: b.data[63:0] = {32'h1234_0000, $urandom};
    endcase
    return b;
  endfunction

  task automatic add_pkt(int kind, int len);
    for (int i = 0; i < len; i++)
      in_q.push_back(rand_beat(i == 0 ? kind : (($urandom % 2) ? 0 : 2), i == len-1));
  endtask

  task automatic model_clear();
    in_q.delete();
    for (int p = 0; p < 3; p++) begin
      expq[p].delete();
      exp_pkt[p] = 0;
      stall_prev[p] = 0;
    end
    exp_drop = 0;
    in_pkt = 0;
    drop_mode = 0;
    lock = 0;
  endtask

  task automatic ingest();
    beat_t b;
    if (!in_pkt) begin
      lock = classify(cur, s_tdata[63:0]);
      drop_mode = (cur == 1) && (lock == 2);
    end
    b.data = s_tdata; b.keep = s_tkeep; b.user = s_tuser; b.last = s_tlast;
    if (drop_mode) begin
      if (s_tlast) exp_drop++;
    end else expq[lock].push_back(b);
    in_pkt = !s_tlast;
  endtask

  // Called right after a negedge with inputs driven; scores this cycle, returns at next negedge.
  task automatic cycle(output bit acc);
    beat_t o, e;
    bit v;
    #1;
    acc = RST && s_tvalid && s_tready[cur];
    if (RST) begin
      for (int p = 0; p < 3; p++) begin
        o.data = m_tdata[cur][p*DW +: DW];
        o.keep = m_tkeep[cur][p*KW +: KW];
        o.user = m_tuser[cur][p*UW +: UW];
        o.last = m_tlast[cur][p];
        v = m_tvalid[cur][p];
        if (stall_prev[p]) begin
          n_checks++;
          if (!v || o !== held[p]) begin
            n_fail++;
            $display("FAIL hold_stable port%0d valid=%0b (required 1 with unchanged beat)", p, v);
          end
        end
        if (v && m_tready[p]) begin
          n_checks++;
          if (expq[p].size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat port%0d got data_lo=%h, no beat expected", p, o.data[63:0]);
          end else begin
            e = expq[p].pop_front();
            if (o !== e) begin
              n_fail++;
              $display("FAIL beat_port%0d got lo=%h last=%0b required lo=%h last=%0b",
                       p, o.data[63:0], o.last, e.data[63:0], e.last);
            end
            if (e.last) exp_pkt[p]++;
          end
        end
        stall_prev[p] = v && !m_tready[p];
        held[p] = o;
      end
      if (acc) ingest();
    end
    @(negedge CLK);
  endtask

  task automatic drive(input beat_t b, input bit v, input logic [2:0] rdy, output bit acc);
    s_tdata = b.data; s_tkeep = b.keep; s_tuser = b.user; s_tlast = b.last;
    s_tvalid = v; m_tready = rdy;
    cycle(acc);
  endtask

  task automatic do_reset();
    bit acc;
    RST = 1'b0; s_tvalid = 1'b0; m_tready = 3'b111;
    model_clear();
    cycle(acc);
    cycle(acc);
    RST = 1'b1;
  endtask

  function automatic bit pending();
    return expq[0].size() > 0 || expq[1].size() > 0 || expq[2].size() > 0;
  endfunction

  task automatic run_traffic(int ready_pct, int valid_pct);
    int budget = 3000;
    bit acc, v;
    beat_t b;
    logic [2:0] r;
    while ((in_q.size() > 0 || pending()) && budget > 0) begin
      b = (in_q.size() > 0) ? in_q[0] : '0;
      v = (in_q.size() > 0) && ($urandom_range(99) < valid_pct);
      for (int p = 0; p < 3; p++) r[p] = ($urandom_range(99) < ready_pct);
      drive(b, v, r, acc);
      if (acc) void'(in_q.pop_front());
      budget--;
    end
    n_checks++;
    if (budget == 0) begin
      n_fail++;
      $display("FAIL traffic_timeout pending input=%0d, required all delivered", in_q.size());
    end
  endtask

  task automatic check_counts(string name);
    for (int p = 0; p < 3; p++) begin
      n_checks++;
      if (pkt_count[cur][p*32 +: 32] !== 32'(exp_pkt[p])) begin
        n_fail++;
        $display("FAIL %s pkt_count[%0d] got %0d required %0d", name, p, pkt_count[cur][p*32 +: 32], exp_pkt[p]);
      end
    end
    n_checks++;
    if (drop_count[cur] !== 32'(exp_drop)) begin
      n_fail++;
      $display("FAIL %s drop_count got %0d required %0d", name, drop_count[cur], exp_drop);
    end
  endtask

  task automatic test_reset();
    cur = 0;
    do_reset();
    #1;
    n_checks++;
    if (m_tvalid[0] !== 3'b000 || m_tdata[0] !== '0 || m_tlast[0] !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs got valid=%b last=%b required 000/000", m_tvalid[0], m_tlast[0]);
    end
    n_checks++;
    if (s_tready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tready got %b required 1", s_tready[0]);
    end
    check_counts("reset");
  endtask

  task automatic test_single_beat();
    bit acc;
    cur = 0;
    do_reset();
    drive(rand_beat(0, 1'b1), 1'b1, 3'b111, acc);
    n_checks++;
    if (!acc) begin n_fail++; $display("FAIL single_accept got 0 required 1"); end
    s_tvalid = 1'b0;
    #1;
    n_checks++;
    if (m_tvalid[0] !== 3'b001 || m_tlast[0][0] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_latency got valid=%b last=%b required 001 last=1", m_tvalid[0], m_tlast[0][0]);
    end
    cycle(acc);
    cycle(acc);
    check_counts("single");
  endtask

  task automatic test_default_route();
    cur = 0;
    do_reset();
    in_q.push_back(rand_beat(2, 1'b0));
    for (int i = 1; i < 4; i++) in_q.push_back(rand_beat(0, i == 3));
    run_traffic(100, 100);
    check_counts("default_route");
  endtask

  task automatic test_back_to_back();
    bit acc;
    beat_t b;
    cur = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      b = rand_beat(1, i == 3);
      drive(b, 1'b1, 3'b111, acc);
      n_checks++;
      if (!acc) begin n_fail++; $display("FAIL b2b_accept beat%0d got 0 required 1", i); end
    end
    s_tvalid = 1'b0;
    #1;
    n_checks++;
    if (m_tvalid[0][1] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_last_visible got %b required 1", m_tvalid[0][1]);
    end
    run_traffic(100, 100);
    check_counts("back_to_back");
  endtask

  task automatic test_backpressure();
    bit acc;
    beat_t b1;
    cur = 0;
    do_reset();
    drive(rand_beat(2, 1'b1), 1'b1, 3'b011, acc);
    drive(rand_beat(0, 1'b0), 1'b1, 3'b011, acc);
    n_checks++;
    if (!acc) begin n_fail++; $display("FAIL bp_first_accept got 0 required 1"); end
    b1 = rand_beat(0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(b1, 1'b1, (k == 2) ? 3'b110 : 3'b010, acc);
      n_checks++;
      if (acc) begin n_fail++; $display("FAIL bp_stall cycle%0d tready got 1 required 0", k); end
      if (k == 3) begin
        n_checks++;
        if (m_tvalid[0][2] !== 1'b0) begin
          n_fail++; $display("FAIL bp_port2_drain got valid=%b required 0", m_tvalid[0][2]);
        end
      end
    end
    in_q.push_back(b1);
    in_q.push_back(rand_beat(2, 1'b0));
    in_q.push_back(rand_beat(0, 1'b1));
    run_traffic(100, 100);
    check_counts("backpressure");
  endtask

  task automatic test_drop();
    bit acc;
    cur = 1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(rand_beat(i == 0 ? 2 : 0, i == 2), 1'b1, 3'b111, acc);
      n_checks++;
      if (!acc) begin n_fail++; $display("FAIL drop_tready beat%0d got 0 required 1", i); end
    end
    s_tvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (m_tvalid[1] !== 3'b000) begin
        n_fail++; $display("FAIL drop_no_output got valid=%b required 000", m_tvalid[1]);
      end
      cycle(acc);
    end
    check_counts("drop");
  endtask

  task automatic test_wildcard();
    cur = 2;
    do_reset();
    add_pkt(0, 2);
    add_pkt(2, 2);
    add_pkt(1, 1);
    add_pkt(0, 1);
    run_traffic(80, 90);
    check_counts("wildcard");
  endtask

  task automatic test_reset_midpkt();
    bit acc;
    cur = 0;
    do_reset();
    drive(rand_beat(0, 1'b0), 1'b1, 3'b111, acc);
    drive(rand_beat(0, 1'b0), 1'b1, 3'b111, acc);
    RST = 1'b0;
    drive(rand_beat(0, 1'b0), 1'b1, 3'b111, acc);
    model_clear();
    RST = 1'b1;
    s_tvalid = 1'b0;
    #1;
    n_checks++;
    if (m_tvalid[0] !== 3'b000 || m_tdata[0] !== '0) begin
      n_fail++; $display("FAIL midreset_outputs got valid=%b required 000 and zero data", m_tvalid[0]);
    end
    check_counts("midreset_counts");
    cycle(acc);
    in_q.push_back(rand_beat(0, 1'b1));
    run_traffic(100, 100);
    check_counts("midreset_after");
  endtask

  task automatic test_random(int d);
    cur = d;
    do_reset();
    for (int i = 0; i < 30; i++) add_pkt($urandom_range(2), $urandom_range(1, 5));
    run_traffic(60, 70);
    check_counts("random");
  endtask

  initial begin
    RST = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 3'b111;
    s_tdata = '0; s_tkeep = '0; s_tuser = '0;
    @(negedge CLK);
    test_reset();
    test_single_beat();
    test_default_route();
    test_back_to_back();
    test_backpressure();
    test_drop();
    test_wildcard();
    test_reset_midpkt();
    for (int d = 0; d < 3; d++) test_random(d);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
